// File: rtl/uart_pkg.sv
// uart_pkg: encodings and defaults shared by the UART transmitter and receiver.
//   uart_state_e     : one-hot frame state (IDLE, START, DATA, PARITY, STOP)
//   DEF_DATA_WIDTH   : default payload width
//   DEF_PRESC_WIDTH  : default width of the prescale input and edge counter
//   PAR_EVEN/PAR_ODD : encodings of the parity-type select
package uart_pkg;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_PRESC_WIDTH = 6;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    START  = 5'b00010,
    DATA   = 5'b00100,
    PARITY = 5'b01000,
    STOP   = 5'b10000
  } uart_state_e;

endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: payload hold/shift register and data bit counter.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   load       : capture load_data and restart at bit 0
//   load_data  : payload to serialise (LSB first)
//   shift      : advance to the next payload bit
//   cur_bit    : payload bit currently selected
//   nxt_bit    : payload bit that becomes current after the next shift
//   last_bit   : the current bit is the final payload bit
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  shift,
  output logic                  cur_bit,
  output logic                  nxt_bit,
  output logic                  last_bit
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shreg_q;
  logic [DATA_WIDTH-1:0] shreg_nxt;
  logic [CNT_W-1:0]      bit_cnt_q;

  assign shreg_nxt = shreg_q >> 1;
  assign cur_bit   = shreg_q[0];
  assign nxt_bit   = shreg_nxt[0];
  assign last_bit  = (bit_cnt_q == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
    end else if (load) begin
      shreg_q   <= load_data;
      bit_cnt_q <= '0;
    end else if (shift) begin
      shreg_q   <= shreg_nxt;
      bit_cnt_q <= last_bit ? '0 : bit_cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter, start + DATA_WIDTH bits LSB first +
// optional parity + stop. Each serial bit lasts `prescale` clocks (0 acts as 1).
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   P_DATA      : byte to transmit, captured on accept
//   DATA_VALID  : send request, sampled only while idle
//   PAR_EN      : 1 = append parity bit
//   PAR_TYP     : 0 = even, 1 = odd parity
//   prescale    : clocks per serial bit
//   STP2_EN     : 1 = two stop bits (present only with UART_TX_TWO_STOP_EN)
//   TX_OUT      : registered serial line, idle high
//   busy        : high from the start bit through the last stop clock
// Build option: define UART_TX_TWO_STOP_EN to add the STP2_EN input.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int PRESC_WIDTH = DEF_PRESC_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  P_DATA,
  input  logic                   DATA_VALID,
  input  logic                   PAR_EN,
  input  logic                   PAR_TYP,
  input  logic [PRESC_WIDTH-1:0] prescale,
`ifdef UART_TX_TWO_STOP_EN
  input  logic                   STP2_EN,
`endif
  output logic                   TX_OUT,
  output logic                   busy
);

  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d,
                                       input logic typ);
    return (^d) ^ (typ == PAR_ODD);
  endfunction

  uart_state_e            state_q, state_d;
  logic [PRESC_WIDTH-1:0] edge_cnt_q;
  logic [PRESC_WIDTH-1:0] presc_q;
  logic [PRESC_WIDTH-1:0] edge_last;
  logic                   par_en_q;
  logic                   parity_q;
  logic                   stp2_q;
  logic                   stop2_q;
  logic                   bit_done;
  logic                   accept;
  logic                   shift;
  logic                   stop_second;
  logic                   tx_d;
  logic                   cur_bit, nxt_bit, last_bit;

  // prescale 0 is treated as 1: the last edge index saturates at 0
  assign edge_last = (presc_q == '0) ? '0 : presc_q - 1'b1;
  assign bit_done  = (edge_cnt_q == edge_last);

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_data (P_DATA),
    .shift     (shift),
    .cur_bit   (cur_bit),
    .nxt_bit   (nxt_bit),
    .last_bit  (last_bit)
  );

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    shift       = 1'b0;
    stop_second = 1'b0;
    case (state_q)
      IDLE: begin
        if (DATA_VALID) begin
          accept  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_done) state_d = DATA;
      end
      DATA: begin
        if (bit_done) begin
          shift = 1'b1;
          if (last_bit) state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_done) state_d = STOP;
      end
      STOP: begin
        if (bit_done) begin
          if (stp2_q && !stop2_q) stop_second = 1'b1;
          else                    state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // line value for the cycle after this edge, decoded from the next state
    tx_d = 1'b1;
    case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift ? nxt_bit : cur_bit;
      PARITY:  tx_d = parity_q;
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      edge_cnt_q <= '0;
      presc_q    <= '0;
      par_en_q   <= 1'b0;
      parity_q   <= 1'b0;
      stp2_q     <= 1'b0;
      stop2_q    <= 1'b0;
      TX_OUT     <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state_q <= state_d;
      TX_OUT  <= tx_d;
      busy    <= (state_d != IDLE);
      if (accept || state_d == IDLE) begin
        edge_cnt_q <= '0;
      end else if (bit_done) begin
        edge_cnt_q <= '0;
      end else begin
        edge_cnt_q <= edge_cnt_q + 1'b1;
      end
      if (accept) begin
        presc_q  <= prescale;
        par_en_q <= PAR_EN;
        parity_q <= calc_parity(P_DATA, PAR_TYP);
`ifdef UART_TX_TWO_STOP_EN
        stp2_q   <= STP2_EN;
`else
        stp2_q   <= 1'b0;
`endif
        stop2_q  <= 1'b0;
      end else if (stop_second) begin
        stop2_q  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] P_DATA = 8'h00;
  logic       DATA_VALID = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [5:0] prescale = 6'd8;
`ifdef UART_TX_TWO_STOP_EN
  logic       STP2_EN = 1'b0;
`endif
  logic       TX_OUT;
  logic       busy;

  uart_tx dut (
    .clk        (clk),
    .rst        (rst),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .prescale   (prescale),
`ifdef UART_TX_TWO_STOP_EN
    .STP2_EN    (STP2_EN),
`endif
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       pen;
    logic       ptyp;
    int         presc;
    logic       stp2;
  } frame_t;

  frame_t exp_q[$];
  int     checks = 0;
  int     failures = 0;
  bit     mon_active = 1'b0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: decodes every frame on TX_OUT against the head of the queue.
  initial begin : monitor
    frame_t e;
    logic   bits [0:12];
    int     nb, eff, b, c, errs, fnum, guard;
    bit     aborted;
    fnum = 0;
    forever begin
      @(negedge clk);
      if (!rst && TX_OUT === 1'b0) begin
        if (exp_q.size() == 0) begin
          check_int("unexpected_frame", 1, 0);
          guard = 0;
          while (TX_OUT === 1'b0 && guard < 5000) begin
            @(negedge clk);
            guard++;
          end
        end else begin
          e = exp_q.pop_front();
          mon_active = 1'b1;
          eff = (e.presc == 0) ? 1 : e.presc;
          bits[0] = 1'b0;
          for (int i = 0; i < 8; i++) bits[1+i] = e.data[i];
          nb = 9;
          if (e.pen) begin
            bits[nb] = (^e.data) ^ e.ptyp;
            nb++;
          end
          bits[nb] = 1'b1;
          nb++;
          if (e.stp2) begin
            bits[nb] = 1'b1;
            nb++;
          end
          b = 0; c = 0; errs = 0; aborted = 1'b0;
          while (b < nb && !aborted) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (rst) begin
              aborted = 1'b1;
            end else begin
              if (TX_OUT !== bits[b] || busy !== 1'b1) errs++;
              c++;
              if (c == eff) begin
                check_int($sformatf("frame%0d_data%02h_bit%0d_exp%0b_bad_cycles",
                                    fnum, e.data, b, bits[b]), errs, 0);
                b++; c = 0; errs = 0;
              end
            end
          end
          if (!aborted) begin
            @(negedge clk);
            check_bit($sformatf("frame%0d_idle_tx", fnum), TX_OUT, 1'b1);
            check_bit($sformatf("frame%0d_idle_busy", fnum), busy, 1'b0);
          end
          fnum++;
          mon_active = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #990000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at posedge+1 with the transmitter idle.
  task automatic send(input logic [7:0] d, input logic pen, input logic ptyp,
                      input int presc, input logic stp2);
    frame_t f;
    P_DATA     = d;
    PAR_EN     = pen;
    PAR_TYP    = ptyp;
    prescale   = 6'(presc);
`ifdef UART_TX_TWO_STOP_EN
    STP2_EN    = stp2;
    f.stp2     = stp2;
`else
    f.stp2     = 1'b0;
`endif
    f.data = d; f.pen = pen; f.ptyp = ptyp; f.presc = presc;
    exp_q.push_back(f);
    DATA_VALID = 1'b1;
    @(posedge clk);
    #1 DATA_VALID = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy !== 1'b0 || mon_active || exp_q.size() != 0) && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 5000) check_int("wait_idle_timeout", n, 0);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       pen;
    logic       ptyp;
    int         presc;
  } vec_t;

  vec_t vecs [0:7];

  initial begin : stimulus
    int n;
    vecs[0] = '{8'h00, 1'b0, 1'b0, 8};
    vecs[1] = '{8'hFF, 1'b1, 1'b0, 8};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 4};
    vecs[3] = '{8'h80, 1'b1, 1'b0, 63};
    vecs[4] = '{8'h01, 1'b0, 1'b0, 4};
    vecs[5] = '{8'h5A, 1'b1, 1'b1, 5};
    vecs[6] = '{8'h7E, 1'b0, 1'b0, 2};
    vecs[7] = '{8'hC9, 1'b1, 1'b0, 0};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_bit("reset_tx", TX_OUT, 1'b1);
    check_bit("reset_busy", busy, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // no parity, 0xA5 at prescale 8
    send(8'hA5, 1'b0, 1'b0, 8, 1'b0);
    check_bit("accept_busy", busy, 1'b1);
    check_bit("accept_start_bit", TX_OUT, 1'b0);
    wait_idle();

    // even and odd parity on 0x03 at prescale 16
    send(8'h03, 1'b1, 1'b0, 16, 1'b0);
    wait_idle();
    send(8'h03, 1'b1, 1'b1, 16, 1'b0);
    wait_idle();

    // request during busy is dropped
    send(8'h55, 1'b0, 1'b0, 8, 1'b0);
    repeat (18) @(posedge clk);
    #1;
    P_DATA = 8'h0F;
    DATA_VALID = 1'b1;
    @(posedge clk);
    #1 DATA_VALID = 1'b0;
    wait_idle();
    repeat (20) @(posedge clk);
    #1;
    check_bit("ignored_req_idle_tx", TX_OUT, 1'b1);
    check_bit("ignored_req_idle_busy", busy, 1'b0);

    // request held through frame end goes out after one idle clock
    send(8'h55, 1'b0, 1'b0, 8, 1'b0);
    repeat (18) @(posedge clk);
    #1;
    P_DATA = 8'h0F;
    DATA_VALID = 1'b1;
    exp_q.push_back('{8'h0F, 1'b0, 1'b0, 8, 1'b0});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== 1'b0 && n < 500);
    check_bit("held_req_reached_idle", busy, 1'b0);
    @(posedge clk);
    #1 DATA_VALID = 1'b0;
    check_bit("held_req_accepted", busy, 1'b1);
    wait_idle();

    // inputs changed after accept do not disturb the frame
    send(8'h96, 1'b1, 1'b0, 8, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    P_DATA = 8'hFF; prescale = 6'd4; PAR_EN = 1'b0; PAR_TYP = 1'b1;
    wait_idle();

    // reset during data bit 3 aborts the frame
    send(8'hC3, 1'b0, 1'b0, 8, 1'b0);
    repeat (34) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check_bit("midframe_reset_tx", TX_OUT, 1'b1);
    check_bit("midframe_reset_busy", busy, 1'b0);
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    send(8'h3C, 1'b1, 1'b1, 8, 1'b0);
    wait_idle();

    // directed table, including prescale extremes
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].d, vecs[i].pen, vecs[i].ptyp, vecs[i].presc, 1'b0);
      wait_idle();
    end

`ifdef UART_TX_TWO_STOP_EN
    send(8'hA5, 1'b1, 1'b0, 8, 1'b1);
    wait_idle();
    send(8'h3C, 1'b0, 1'b0, 8, 1'b1);
    wait_idle();
`endif

    repeat (10) @(posedge clk);
    #1;
    check_int("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
